// File: rtl/cordic_linear_divider_if.sv
// Request/result bundle for the CORDIC linear divider: operands in, quotient and flags out.
interface cordic_linear_divider_if #(
  parameter int INT_SIZE   = 8,
  parameter int FLOAT_SIZE = 24
);
  localparam int W = INT_SIZE + FLOAT_SIZE;

  logic         start;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, num, den,
    input  ready, busy, done, quot, div_by_zero, overflow
  );

  modport slave (
    input  start, num, den,
    output ready, busy, done, quot, div_by_zero, overflow
  );
endinterface

// File: rtl/cordic_linear_divider.sv
// Signed fixed-point divider using range normalisation and linear-mode CORDIC vectoring.
// Result after k+n+2 cycles (k = normalisation shift, n = micro-rotations); start is ignored unless ready.
module cordic_linear_divider #(
  parameter int FLOAT_SIZE = 24,
  parameter int INT_SIZE   = 8,
  parameter int ITERATIONS = INT_SIZE + FLOAT_SIZE
) (
  input logic                    clk,
  input logic                    rst,
  cordic_linear_divider_if.slave bus
);
  localparam int W  = INT_SIZE + FLOAT_SIZE;
  localparam int MW = W + 1;
  localparam int BW = W + INT_SIZE - 1;
  localparam int YW = W + INT_SIZE + 1;
  localparam int KW = (INT_SIZE > 2) ? $clog2(INT_SIZE) : 1;
  localparam int SW = $clog2(W);
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS + 1) : 1;
  localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, ITER, FIX} state_t;

  state_t               state, state_n;
  logic                 sgn, sgn_n;
  logic [MW-1:0]        a, a_n, b, b_n;
  logic [KW-1:0]        k, k_n;
  logic signed [YW-1:0] y, y_n;
  logic signed [W-1:0]  z, z_n;
  logic [SW-1:0]        sh, sh_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 done, done_n;
  logic                 dbz, dbz_n;
  logic                 ovf, ovf_n;
  logic [W-1:0]         quot, quot_n;

  logic [BW-1:0]        bk;
  logic signed [YW-1:0] bk_y;
  logic signed [W-1:0]  step;
  logic signed [W-1:0]  z_fix;
  int                   n_iter;

  assign bk   = BW'(b) << k;
  assign bk_y = YW'(bk);
  assign step = W'(1) << sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sgn   <= 1'b0;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      y     <= '0;
      z     <= '0;
      sh    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      quot  <= '0;
    end else begin
      state <= state_n;
      sgn   <= sgn_n;
      a     <= a_n;
      b     <= b_n;
      k     <= k_n;
      y     <= y_n;
      z     <= z_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      done  <= done_n;
      dbz   <= dbz_n;
      ovf   <= ovf_n;
      quot  <= quot_n;
    end
  end

  always_comb begin
    state_n = state;
    sgn_n   = sgn;
    a_n     = a;
    b_n     = b;
    k_n     = k;
    y_n     = y;
    z_n     = z;
    sh_n    = sh;
    cnt_n   = cnt;
    done_n  = 1'b0;
    dbz_n   = dbz;
    ovf_n   = ovf;
    quot_n  = quot;
    n_iter  = 0;
    z_fix   = z;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sgn_n = bus.num[W-1] ^ bus.den[W-1];
          a_n   = bus.num[W-1] ? MW'(0) - {1'b1, bus.num} : {1'b0, bus.num};
          b_n   = bus.den[W-1] ? MW'(0) - {1'b1, bus.den} : {1'b0, bus.den};
          k_n   = '0;
          dbz_n = 1'b0;
          ovf_n = 1'b0;
          if (bus.den == '0) begin
            dbz_n  = 1'b1;
            done_n = 1'b1;
            quot_n = (bus.num == '0) ? '0 : (bus.num[W-1] ? Q_MIN : Q_MAX);
          end else begin
            state_n = NORM;
          end
        end
      end

      NORM: begin
        if (BW'(a) < bk) begin
          n_iter  = (ITERATIONS < int'(k) + FLOAT_SIZE) ? ITERATIONS : int'(k) + FLOAT_SIZE;
          cnt_n   = CW'(n_iter);
          sh_n    = SW'(int'(k) + FLOAT_SIZE - 1);
          // Residual is kept scaled by 2^(k-e) so every right shift of b becomes a left shift of y.
          y_n     = YW'({a, 1'b0});
          z_n     = '0;
          state_n = ITER;
        end else if (k == KW'(INT_SIZE - 1)) begin
          ovf_n   = 1'b1;
          done_n  = 1'b1;
          quot_n  = sgn ? Q_MIN : Q_MAX;
          state_n = IDLE;
        end else begin
          k_n = k + 1'b1;
        end
      end

      ITER: begin
        if (!y[YW-1]) begin
          y_n = (y - bk_y) <<< 1;
          z_n = z + step;
        end else begin
          y_n = (y + bk_y) <<< 1;
          z_n = z - step;
        end
        if (cnt == CW'(1)) begin
          state_n = FIX;
        end else begin
          cnt_n = cnt - 1'b1;
          sh_n  = sh - 1'b1;
        end
      end

      FIX: begin
        z_fix   = y[YW-1] ? z - step : z;
        quot_n  = sgn ? -z_fix : z_fix;
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.ready       = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.quot        = quot;
  assign bus.div_by_zero = dbz;
  assign bus.overflow    = ovf;
endmodule
